// File: rtl/iomem_pkg.sv
// ---------------------------------------------------------------------------
// iomem_pkg
// Shared definitions for the iomem bus router and related bus bridges.
//   state_t        : router FSM states
//   IOMEM_BASE     : default address window, compared against addr[31:24]
//   IOMEM_ERR_DATA : default read data for aborted or unmapped accesses
//   slot_bits()    : width of the slot index field for a given slot count
// ---------------------------------------------------------------------------
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0]  IOMEM_BASE     = 8'h03;
    localparam logic [31:0] IOMEM_ERR_DATA = 32'hDEAD_BEEF;

    // At least one bit, so that a single-slot build still has a real index
    // field (addr[16]) that must be zero to be mapped.
    function automatic int slot_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iomem_timeout.sv
// ---------------------------------------------------------------------------
// iomem_timeout
// Loadable down-counter used as an access watchdog by iomem bus masters.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset (count = 0)
//   load       in   load count with load_value (has priority over en)
//   en         in   decrement count by one while it is non-zero
//   load_value in   WIDTH-bit reload value
//   expire     out  high while count == 1, i.e. the last allowed cycle
// ---------------------------------------------------------------------------
module iomem_timeout #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // NOTE: state is written with non-blocking assignments so every register
    // samples its inputs at the same clock edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/iomem_router.sv
// ---------------------------------------------------------------------------
// iomem_router
// Claims master accesses whose addr[31:24] equals BASE, routes each to one of
// NSLOTS peripheral slots selected by addr[16 +: SB], runs the valid/ready
// handshake with that slot, and answers the master with a one-cycle m_ready.
// Hung slots (no ready within TIMEOUT cycles) and unmapped slot numbers get
// ERR_DATA with a one-cycle err pulse so the CPU never stalls.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   m_valid/m_ready          master request / one-cycle completion pulse
//   m_wstrb/m_addr/m_wdata   master request payload (wstrb 0 = read)
//   m_rdata                  registered response data, held until next done
//   s_valid                  one-hot slot request
//   s_wstrb/s_addr/s_wdata   payload latched at claim, stable through REQ
//   s_ready/s_rdata          per-slot completion and data (slot i at 32*i)
//   err                      one-cycle pulse with m_ready on abort/unmapped
// ---------------------------------------------------------------------------
module iomem_router
    import iomem_pkg::*;
#(
    parameter int          NSLOTS   = 4,
    parameter logic [7:0]  BASE     = IOMEM_BASE,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = IOMEM_ERR_DATA
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [3:0]           m_wstrb,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    output logic [31:0]          m_rdata,
    output logic [NSLOTS-1:0]    s_valid,
    output logic [3:0]           s_wstrb,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    input  logic [NSLOTS-1:0]    s_ready,
    input  logic [NSLOTS*32-1:0] s_rdata,
    output logic                 err
);

    localparam int          SB       = slot_bits(NSLOTS);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [31:0] NSLOTS_U = NSLOTS;

    state_t          state;
    logic [SB-1:0]   sel;          // slot owning the access in flight
    logic [SB-1:0]   slot_idx;
    logic            mapped;
    logic            claim;
    logic            sel_ready;
    logic [31:0]     sel_rdata;
    logic            timer_expire;

    // Decode of the incoming request and mux of the selected slot's response.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        slot_idx  = m_addr[16 +: SB];
        mapped    = 1'b0;
        claim     = 1'b0;
        sel_ready = 1'b0;
        sel_rdata = '0;

        // Bits above the slot field inside addr[23:16] must all be zero.
        mapped = ((m_addr[23:16] >> SB) == 8'd0) && (32'(slot_idx) < NSLOTS_U);
        // The !m_ready term blocks a re-claim while the master still holds
        // m_valid during the RESP cycle.
        claim  = (state == IDLE) && m_valid && !m_ready && (m_addr[31:24] == BASE);

        sel_ready = s_ready[sel];
        sel_rdata = s_rdata[32*sel +: 32];
    end

    iomem_timeout #(
        .WIDTH (TW)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (claim && mapped),
        .en         (state == REQ),
        .load_value (TW'(TIMEOUT)),
        .expire     (timer_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            m_ready <= 1'b0;
            err     <= 1'b0;
            m_rdata <= '0;
            s_valid <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m_ready <= 1'b0;
                    err     <= 1'b0;
                    if (claim) begin
                        if (mapped) begin
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                            s_wstrb <= m_wstrb;
                            s_valid <= NSLOTS'(1) << slot_idx;
                            sel     <= slot_idx;
                            state   <= REQ;
                        end else begin
                            m_rdata <= ERR_DATA;
                            err     <= 1'b1;
                            m_ready <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end

                REQ: begin
                    // Ready is tested first so it wins over a same-cycle expiry.
                    if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        state   <= RESP;
                    end else if (timer_expire) begin
                        m_rdata <= ERR_DATA;
                        s_valid <= '0;
                        err     <= 1'b1;
                        m_ready <= 1'b1;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    m_ready <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_router.sv
// ---------------------------------------------------------------------------
// tb_iomem_router
// Directed bench for iomem_router (NSLOTS=4, TIMEOUT=8). Expected responses
// are queued when a request is issued and compared when m_ready appears.
// ---------------------------------------------------------------------------
module tb_iomem_router;

    localparam int NSLOTS  = 4;
    localparam int TIMEOUT = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic                 clk;
    logic                 reset;
    logic                 m_valid;
    logic                 m_ready;
    logic [3:0]           m_wstrb;
    logic [31:0]          m_addr;
    logic [31:0]          m_wdata;
    logic [31:0]          m_rdata;
    logic [NSLOTS-1:0]    s_valid;
    logic [3:0]           s_wstrb;
    logic [31:0]          s_addr;
    logic [31:0]          s_wdata;
    logic [NSLOTS-1:0]    s_ready;
    logic [NSLOTS*32-1:0] s_rdata;
    logic                 err;

    iomem_router #(
        .NSLOTS   (NSLOTS),
        .BASE     (8'h03),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERRD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_wstrb (m_wstrb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .s_valid (s_valid),
        .s_wstrb (s_wstrb),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reqc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access and act as master and slot until m_ready or budget.
    // The slot raises s_ready once it has seen more than 'delay' REQ cycles.
    task automatic do_access(input string name, input logic [31:0] addr,
                             input logic [3:0] wstrb, input logic [31:0] wdata,
                             input int slot, input int delay, input logic [31:0] rdata,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input int exp_lat, input int exp_reqc);
        exp_t e;
        exp_t got;
        int   cyc;
        int   reqc;
        bit   done;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.reqc  = exp_reqc;
        sb.push_back(e);
        s_rdata[32*slot +: 32] = rdata;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        m_valid = 1'b1;
        cyc  = 0;
        reqc = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (m_ready) begin
                done = 1'b1;
                got  = sb.pop_front();
                check({name, "_rdata"},   m_rdata,     got.rdata);
                check({name, "_err"},     32'(err),    32'(got.err));
                check({name, "_latency"}, 32'(cyc),    32'(got.lat));
                check({name, "_req_cyc"}, 32'(reqc),   32'(got.reqc));
                check({name, "_sv_done"}, 32'(s_valid), 32'd0);
                m_valid = 1'b0;
                s_ready = '0;
            end else if (s_valid != '0) begin
                reqc++;
                check({name, "_s_valid"}, 32'(s_valid), 32'd1 << slot);
                check({name, "_s_addr"},  s_addr,       addr);
                check({name, "_s_wdata"}, s_wdata,      wdata);
                check({name, "_s_wstrb"}, 32'(s_wstrb), 32'(wstrb));
                // Master payload changes must not reach the latched slot side.
                m_addr  = ~addr;
                m_wdata = ~wdata;
                m_wstrb = ~wstrb;
                s_ready[slot] = (reqc > delay);
            end
        end
        if (!done) begin
            check({name, "_hang"}, 32'd0, 32'd1);
            m_valid = 1'b0;
            s_ready = '0;
            if (sb.size() != 0) void'(sb.pop_front());
        end
        @(negedge clk);
        check({name, "_ready_pulse"}, 32'(m_ready), 32'd0);
        check({name, "_err_pulse"},   32'(err),     32'd0);
        check({name, "_rdata_hold"},  m_rdata,      exp_rdata);
    endtask

    int seen;

    initial begin
        reset   = 1'b1;
        m_valid = 1'b0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ready = '0;
        s_rdata = '0;

        #12;
        check("rst_m_ready", 32'(m_ready), 32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_m_rdata", m_rdata,      32'd0);
        check("rst_s_addr",  s_addr,       32'd0);
        check("rst_s_wdata", s_wdata,      32'd0);
        check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Read, slot 0 answers in its first REQ cycle.
        do_access("rd0", 32'h0300_0000, 4'b0000, 32'h0, 0, 0, 32'h1234_5678,
                  32'h1234_5678, 1'b0, 2, 1);

        // Write, slot 1 answers 3 cycles into REQ; other slots' ready ignored.
        s_ready = 4'b1101;
        do_access("wr1", 32'h0301_0004, 4'b0011, 32'hA5A5_00FF, 1, 3, 32'h7777_1111,
                  32'h7777_1111, 1'b0, 2 + 3, 3 + 1);

        // Timeout, slot 2 never ready while the others are.
        s_ready = 4'b1011;
        do_access("tmo2", 32'h0302_0008, 4'b0000, 32'h0, 2, 1000, 32'h5555_AAAA,
                  ERRD, 1'b1, TIMEOUT + 1, TIMEOUT);

        // Unmapped slot number within the window.
        do_access("unmap", 32'h0305_0000, 4'b0000, 32'h0, 0, 0, 32'h0,
                  ERRD, 1'b1, 1, 0);

        // Address owned by another decoder: no reaction at all.
        m_addr  = 32'h0200_0000;
        m_wstrb = 4'b0000;
        m_valid = 1'b1;
        seen    = 0;
        repeat (300) begin
            @(negedge clk);
            if (m_ready || err || (s_valid != '0)) seen++;
        end
        check("foreign_no_resp", 32'(seen), 32'd0);
        m_valid = 1'b0;
        @(negedge clk);

        // Ready arrives in the very cycle the timer expires: ready wins.
        do_access("race2", 32'h0302_0010, 4'b0000, 32'h0, 2, TIMEOUT - 1, 32'h0BAD_C0DE,
                  32'h0BAD_C0DE, 1'b0, 2 + TIMEOUT - 1, TIMEOUT);

        // Reset asserted between clock edges in the middle of REQ.
        s_ready = '0;
        m_addr  = 32'h0301_0020;
        m_wdata = 32'h0;
        m_wstrb = 4'b0000;
        m_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_s_valid", 32'(s_valid), 32'h2);
        #2 reset = 1'b1;
        #1;
        check("async_s_valid", 32'(s_valid), 32'd0);
        check("async_m_ready", 32'(m_ready), 32'd0);
        check("async_err",     32'(err),     32'd0);
        check("async_m_rdata", m_rdata,      32'd0);
        check("async_s_addr",  s_addr,       32'd0);
        m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Fresh read to slot 3 after the abort.
        do_access("rd3", 32'h0303_0010, 4'b0000, 32'h0, 3, 1, 32'hCAFE_F00D,
                  32'hCAFE_F00D, 1'b0, 2 + 1, 1 + 1);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iomem_router.md
Name: iomem_router

Overview:
- Controller for the SoC's iomem bus. Decodes master requests in one address window and routes each to one of NSLOTS peripheral slots (GPIO/LED, future UART2, timers).
- Sequences the valid/ready handshake toward the slot and returns the slot's data to the master.
- Enforces a per-access timeout and converts hung or unmapped accesses into an error response, so the CPU never stalls.
- Sits between the picosoc iomem port and the board-level peripheral registers.

Parameters:
- NSLOTS, 4, number of peripheral slots (1..16).
- BASE, 8'h03, required value of addr[31:24] for a claimed access.
- TIMEOUT, 255, maximum cycles in REQ before abort (≥1).
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout or unmapped slot.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  master request valid
- m_ready  out  1  one-cycle completion pulse to master
- m_wstrb  in  4  byte write strobes (0 = read)
- m_addr  in  32  master address
- m_wdata  in  32  master write data
- m_rdata  out  32  registered response data
- s_valid  out  NSLOTS  one-hot slot request
- s_wstrb  out  4  latched strobes to slots
- s_addr  out  32  latched address to slots
- s_wdata  out  32  latched write data to slots
- s_ready  in  NSLOTS  per-slot completion
- s_rdata  in  NSLOTS*32  per-slot read data, slot i at [32*i +: 32]
- err  out  1  one-cycle pulse on timeout or unmapped access

Behaviour:
- Reset (async, immediate): state IDLE; m_ready, s_valid, err = 0; m_rdata, s_addr, s_wdata, s_wstrb = 0; timer = 0.
- Slot decode: SB = clog2(NSLOTS). slot = m_addr[16 +: SB]. The access is mapped iff m_addr[23:16+SB] == 0 and slot < NSLOTS.
- IDLE:
  - If m_valid && !m_ready && m_addr[31:24]==BASE:
    - Mapped: latch addr/wdata/wstrb into s_*, set s_valid[slot], load timer = TIMEOUT, go REQ.
    - Unmapped: m_rdata <= ERR_DATA, err <= 1, go RESP.
  - BASE mismatch: no action, no response (another decoder owns it).
- REQ:
  - s_ready[slot] high: m_rdata <= s_rdata[slot], clear s_valid, go RESP.
  - Else timer==1: clear s_valid, m_rdata <= ERR_DATA, err <= 1, go RESP.
  - Else timer decrements.
  - s_ready on non-selected slots is ignored.
  - s_ready and timer expiry in the same cycle: ready wins, normal data, no err.
- RESP: m_ready = 1 for exactly one cycle, then IDLE. The master drops m_valid after ready; the !m_ready guard prevents re-claim in the RESP cycle.
- err is high in the RESP cycle only. m_rdata holds until the next completion.
- Writes: s_rdata is captured and returned anyway; picosoc ignores it.
- Latency, valid to m_ready:
  - Mapped, slot ready combinationally: 2 cycles.
  - Slot ready k cycles into REQ: 2+k cycles.
  - Unmapped: 1 cycle.
  - Timeout: TIMEOUT+1 cycles.
- s_addr/s_wdata/s_wstrb are stable for the whole REQ phase, regardless of m_* changes.
- m_valid dropping during REQ is a protocol violation. The router completes the access anyway.
- Reset asserted in any state aborts the access; s_valid falls without waiting for a clock edge.

Decomposition:
- Shared package iomem_pkg: state enum {IDLE, REQ, RESP}, IOMEM_BASE default 8'h03, ERR_DATA default, slot-index width function.
- One sub-module, iomem_timeout: loadable down-counter with load/enable inputs and an expire output, width clog2(TIMEOUT+1). It is reused by future bus bridges.
- Decode, mux and FSM stay in iomem_router.

Test Plan:
- Read, slot 0 ready immediately: m_addr=0x0300_0000, wstrb=0, s_rdata[0]=0x1234_5678 → s_valid=4'b0001 for 1 cycle, m_ready pulse 2 cycles after valid, m_rdata=0x1234_5678, err=0.
- Write, slot 1 ready after 3 cycles: m_addr=0x0301_0004, wstrb=4'b0011, wdata=0xA5A5_00FF → s_valid=4'b0010 held 4 cycles, s_addr/s_wdata/s_wstrb match and stay stable, single m_ready pulse.
- Timeout (TIMEOUT=8), slot 2 never ready → s_valid[2] high 8 cycles then low, m_rdata=0xDEAD_BEEF, err and m_ready pulse together once.
- Unmapped: m_addr=0x0305_0000 (NSLOTS=4) → no s_valid, m_ready + err 1 cycle after valid, m_rdata=0xDEAD_BEEF. Then m_addr=0x0200_0000 → no s_valid, no m_ready for 300 cycles.
- Race: s_ready[2] asserted in the same cycle the timer expires → m_rdata=s_rdata[2], err=0.
- Reset asserted mid-REQ, off clock edge → s_valid=0 and m_ready=0 immediately. After release, a fresh read to slot 3 completes normally.
